time_set_ctrl: RTL

Front-panel time-setting controller that sits upstream of the MM:SS counter and display multiplexer. It debounces two raw push-buttons and runs a RUN/SET_MIN/SET_SEC state machine. While setting, it freezes the counter and edits BCD minutes/seconds, with the edited field blinking on the display. On leaving SET_SEC it hands the new time to the counter with a one-cycle load pulse.

---
 rtl/clock_pkg.sv | 54 +++++
 rtl/btn_debounce.sv | 56 +++++
 rtl/time_set_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the MM:SS clock front panel and counter.
//   state_t        : time_set_ctrl state encoding (also drives the mode output)
//   UNITS_MAX      : largest legal BCD units digit
//   TENS_MAX       : largest legal BCD tens digit for minutes/seconds
//   BLANK_*        : bit positions inside the 4-bit display blank mask
//   bcd_inc()      : +1 on a two-digit BCD minute/second value, 59 -> 00
//   sanitize_*()   : force out-of-range digits to 0
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_MIN = 2'd1,
        ST_SET_SEC = 2'd2
    } state_t;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    localparam int BLANK_MIN_DECS = 3;
    localparam int BLANK_MIN_ONES = 2;
    localparam int BLANK_SEC_DECS = 1;
    localparam int BLANK_SEC_ONES = 0;

    // bcd = {tens, ones}; the carry out of 59 is dropped on purpose.
    function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = bcd[7:4];
        ones = bcd[3:0];
        if (ones >= UNITS_MAX) begin
            ones = 4'd0;
            if (tens >= TENS_MAX) begin
                tens = 4'd0;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    function automatic logic [3:0] sanitize_units(input logic [3:0] d);
        return (d > UNITS_MAX) ? 4'd0 : d;
    endfunction

    function automatic logic [3:0] sanitize_tens(input logic [3:0] d);
        return (d > TENS_MAX) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, debounce counter and press pulse for one active-low
// push-button.
//   CLOCK_50 : system clock
//   res_n    : asynchronous active-low reset
//   btn_n    : raw button level, active-low, asynchronous to CLOCK_50
//   press    : one-cycle pulse after the stable level goes released->pressed
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic res_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_0_n;
    logic             sync_1_n;
    logic             stable_n;
    logic             stable_d_n;
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n) begin
            sync_0_n   <= 1'b1;
            sync_1_n   <= 1'b1;
            stable_n   <= 1'b1;
            stable_d_n <= 1'b1;
            db_cnt     <= '0;
            press      <= 1'b0;
        end else begin
            sync_0_n   <= btn_n;
            sync_1_n   <= sync_0_n;
            stable_d_n <= stable_n;
            // The sample that takes the count to DB_CYCLES flips the level.
            if (sync_1_n != stable_n) begin
                if (db_cnt == CNT_LAST) begin
                    stable_n <= sync_1_n;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
            // Only the released->pressed edge makes an event.
            press <= ~stable_n & stable_d_n;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Front-panel time-setting controller for the MM:SS counter. Debounces the
// MODE and INC buttons, freezes the counter while minutes/seconds are edited,
// blinks the edited field and hands the new time over with a load pulse.
//   CLOCK_50      : system clock
//   res_n         : asynchronous active-low reset
//   btn_mode_n    : raw MODE button, active-low
//   btn_inc_n     : raw INC button, active-low
//   cur_*         : current BCD time from the counter
//   run_en        : counter count-enable
//   load          : one-cycle pulse, counter takes load_*
//   load_*        : edited BCD time, held between loads
//   blank_mask    : per-digit blank request {min_decs, min_ones, sec_decs, sec_ones}
//   mode          : 0 RUN, 1 SET_MIN, 2 SET_SEC
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | counter runs, display steady
// ST_SET_MIN | counter frozen, INC bumps minutes, minute digits blink
// ST_SET_SEC | counter frozen, INC bumps seconds, second digits blink;
//            | MODE returns to RUN with a load pulse
// -----------------------------------------------------------------------------
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DB_CYCLES    = 500000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       res_n,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    input  logic [3:0] cur_min_decs,
    input  logic [3:0] cur_min_ones,
    input  logic [3:0] cur_sec_decs,
    input  logic [3:0] cur_sec_ones,
    output logic       run_en,
    output logic       load,
    output logic [3:0] load_min_decs,
    output logic [3:0] load_min_ones,
    output logic [3:0] load_sec_decs,
    output logic [3:0] load_sec_ones,
    output logic [3:0] blank_mask,
    output logic [1:0] mode
);

    localparam int BL_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    logic mode_ev;
    logic inc_ev;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .CLOCK_50 (CLOCK_50),
        .res_n    (res_n),
        .btn_n    (btn_mode_n),
        .press    (mode_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .CLOCK_50 (CLOCK_50),
        .res_n    (res_n),
        .btn_n    (btn_inc_n),
        .press    (inc_ev)
    );

    state_t            state_q, state_d;
    logic [7:0]        edit_min_q, edit_min_d;
    logic [7:0]        edit_sec_q, edit_sec_d;
    logic [7:0]        ld_min_q, ld_min_d;
    logic [7:0]        ld_sec_q, ld_sec_d;
    logic              load_q, load_d;
    logic              run_en_q, run_en_d;
    logic [3:0]        blank_q, blank_d;
    logic [BL_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;

    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n) begin
            state_q     <= ST_RUN;
            edit_min_q  <= '0;
            edit_sec_q  <= '0;
            ld_min_q    <= '0;
            ld_sec_q    <= '0;
            load_q      <= 1'b0;
            run_en_q    <= 1'b1;
            blank_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_min_q  <= edit_min_d;
            edit_sec_q  <= edit_sec_d;
            ld_min_q    <= ld_min_d;
            ld_sec_q    <= ld_sec_d;
            load_q      <= load_d;
            run_en_q    <= run_en_d;
            blank_q     <= blank_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        edit_min_d  = edit_min_q;
        edit_sec_d  = edit_sec_q;
        ld_min_d    = ld_min_q;
        ld_sec_d    = ld_sec_q;
        load_d      = 1'b0;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        blank_d     = '0;

        // MODE has priority; a coincident INC is dropped.
        case (state_q)
            ST_RUN: begin
                if (mode_ev) begin
                    state_d    = ST_SET_MIN;
                    edit_min_d = {sanitize_tens(cur_min_decs), sanitize_units(cur_min_ones)};
                    edit_sec_d = {sanitize_tens(cur_sec_decs), sanitize_units(cur_sec_ones)};
                end
            end
            ST_SET_MIN: begin
                if (mode_ev) begin
                    state_d = ST_SET_SEC;
                end else if (inc_ev) begin
                    edit_min_d = bcd_inc(edit_min_q);
                end
            end
            ST_SET_SEC: begin
                if (mode_ev) begin
                    state_d  = ST_RUN;
                    load_d   = 1'b1;
                    ld_min_d = edit_min_q;
                    ld_sec_d = edit_sec_q;
                end else if (inc_ev) begin
                    edit_sec_d = bcd_inc(edit_sec_q);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        run_en_d = (state_d == ST_RUN);

        // Entering a state, sitting in RUN, or an edit all restart the blink
        // with the digits visible.
        if ((state_d != state_q) || (state_d == ST_RUN) || inc_ev) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BL_W'(1);
        end

        if (state_d == ST_SET_MIN) begin
            blank_d[BLANK_MIN_DECS] = phase_d;
            blank_d[BLANK_MIN_ONES] = phase_d;
        end else if (state_d == ST_SET_SEC) begin
            blank_d[BLANK_SEC_DECS] = phase_d;
            blank_d[BLANK_SEC_ONES] = phase_d;
        end
    end

    assign run_en        = run_en_q;
    assign load          = load_q;
    assign load_min_decs = ld_min_q[7:4];
    assign load_min_ones = ld_min_q[3:0];
    assign load_sec_decs = ld_sec_q[7:4];
    assign load_sec_ones = ld_sec_q[3:0];
    assign blank_mask    = blank_q;
    assign mode          = state_q;

endmodule
